// File: rtl/control_unit_if.sv
// Opcode-in / control-out bundle between the instruction register, the main decoder and the datapath.
interface control_unit_if;
    logic [5:0] opcode;
    logic       regWr;
    logic [1:0] AluOp;
    logic       AluSrc;
    logic       Ext;
    logic       Wresult;
    logic       Bw2;
    logic       MemRd;
    logic       MemWr;
    logic [1:0] pc_control;
    logic       DMadd;
    logic       DMdata;
    logic       SP;

    modport master (
        output opcode,
        input  regWr, AluOp, AluSrc, Ext, Wresult, Bw2, MemRd, MemWr,
        input  pc_control, DMadd, DMdata, SP
    );

    modport slave (
        input  opcode,
        output regWr, AluOp, AluSrc, Ext, Wresult, Bw2, MemRd, MemWr,
        output pc_control, DMadd, DMdata, SP
    );
endinterface

// File: rtl/control_unit.sv
// Main decoder: maps the 6-bit opcode to datapath controls, registered with one cycle of latency.
module control_unit (
    input  logic          clock,
    input  logic          reset,
    control_unit_if.slave bus
);

    localparam logic [5:0] OpAnd   = 6'd1;
    localparam logic [5:0] OpAdd   = 6'd2;
    localparam logic [5:0] OpSub   = 6'd3;
    localparam logic [5:0] OpAndi  = 6'd4;
    localparam logic [5:0] OpAddi  = 6'd5;
    localparam logic [5:0] OpLw    = 6'd6;
    localparam logic [5:0] OpLwPoi = 6'd7;
    localparam logic [5:0] OpSw    = 6'd8;
    localparam logic [5:0] OpBgt   = 6'd9;
    localparam logic [5:0] OpBlt   = 6'd10;
    localparam logic [5:0] OpBeq   = 6'd11;
    localparam logic [5:0] OpBne   = 6'd12;
    localparam logic [5:0] OpJmp   = 6'd13;
    localparam logic [5:0] OpCall  = 6'd14;
    localparam logic [5:0] OpRet   = 6'd15;
    localparam logic [5:0] OpPush  = 6'd16;
    localparam logic [5:0] OpPop   = 6'd17;

    localparam logic [1:0] AluAnd = 2'b00;
    localparam logic [1:0] AluAdd = 2'b01;
    localparam logic [1:0] AluSub = 2'b10;

    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcReturn = 2'b11;

    typedef struct packed {
        logic       reg_wr;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       ext;
        logic       wresult;
        logic       bw2;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] pc_control;
        logic       dm_add;
        logic       dm_data;
        logic       sp;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // All-zero is the NOP encoding; unused opcodes fall through to it.
    always_comb begin
        ctrl_d = '0;
        case (bus.opcode)
            OpAnd: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.alu_op = AluAnd;
            end
            OpAdd: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.alu_op = AluAdd;
            end
            OpSub: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.alu_op = AluSub;
            end
            OpAndi: begin
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.alu_op  = AluAnd;
                ctrl_d.alu_src = 1'b1;
            end
            OpAddi: begin
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.alu_op  = AluAdd;
                ctrl_d.alu_src = 1'b1;
                ctrl_d.ext     = 1'b1;
            end
            OpLw, OpLwPoi: begin
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.alu_op  = AluAdd;
                ctrl_d.alu_src = 1'b1;
                ctrl_d.ext     = 1'b1;
                ctrl_d.mem_rd  = 1'b1;
                ctrl_d.wresult = 1'b1;
                ctrl_d.bw2     = (bus.opcode == OpLwPoi);
            end
            OpSw: begin
                ctrl_d.alu_op  = AluAdd;
                ctrl_d.alu_src = 1'b1;
                ctrl_d.ext     = 1'b1;
                ctrl_d.mem_wr  = 1'b1;
            end
            OpBgt, OpBlt, OpBeq, OpBne: begin
                ctrl_d.alu_op     = AluSub;
                ctrl_d.ext        = 1'b1;
                ctrl_d.pc_control = PcBranch;
            end
            OpJmp: begin
                ctrl_d.pc_control = PcJump;
            end
            OpCall: begin
                ctrl_d.pc_control = PcJump;
                ctrl_d.mem_wr     = 1'b1;
                ctrl_d.dm_add     = 1'b1;
                ctrl_d.dm_data    = 1'b1;
                ctrl_d.sp         = 1'b1;
            end
            OpRet: begin
                ctrl_d.pc_control = PcReturn;
                ctrl_d.mem_rd     = 1'b1;
                ctrl_d.dm_add     = 1'b1;
                ctrl_d.sp         = 1'b1;
            end
            OpPush: begin
                ctrl_d.mem_wr = 1'b1;
                ctrl_d.dm_add = 1'b1;
                ctrl_d.sp     = 1'b1;
            end
            OpPop: begin
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.mem_rd  = 1'b1;
                ctrl_d.wresult = 1'b1;
                ctrl_d.dm_add  = 1'b1;
                ctrl_d.sp      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.regWr      = ctrl_q.reg_wr;
    assign bus.AluOp      = ctrl_q.alu_op;
    assign bus.AluSrc     = ctrl_q.alu_src;
    assign bus.Ext        = ctrl_q.ext;
    assign bus.Wresult    = ctrl_q.wresult;
    assign bus.Bw2        = ctrl_q.bw2;
    assign bus.MemRd      = ctrl_q.mem_rd;
    assign bus.MemWr      = ctrl_q.mem_wr;
    assign bus.pc_control = ctrl_q.pc_control;
    assign bus.DMadd      = ctrl_q.dm_add;
    assign bus.DMdata     = ctrl_q.dm_data;
    assign bus.SP         = ctrl_q.sp;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random opcodes checked against a per-signal rule model.
module tb_control_unit;

    localparam int NOP = 0, AND = 1, ADD = 2, SUB = 3, ANDI = 4, ADDI = 5, LW = 6, LW_POI = 7;
    localparam int SW = 8, BGT = 9, BLT = 10, BEQ = 11, BNE = 12, JMP = 13, CALL = 14, RET = 15;
    localparam int PUSH = 16, POP = 17;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    control_unit_if bus ();

    control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector order: regWr, AluOp, AluSrc, Ext, Wresult, Bw2, MemRd, MemWr, pc_control, DMadd, DMdata, SP
    function automatic logic [13:0] observed();
        return {bus.regWr, bus.AluOp, bus.AluSrc, bus.Ext, bus.Wresult, bus.Bw2, bus.MemRd,
                bus.MemWr, bus.pc_control, bus.DMadd, bus.DMdata, bus.SP};
    endfunction

    // Each output is described as the set of instructions that assert it.
    function automatic logic [13:0] model(int op);
        logic       reg_wr, alu_src, ext, wres, bw2, mrd, mwr, dma, dmd, sp;
        logic [1:0] alu, pc;
        reg_wr  = op inside {AND, ADD, SUB, ANDI, ADDI, LW, LW_POI, POP};
        alu     = (op inside {ADD, ADDI, LW, LW_POI, SW}) ? 2'b01 :
                  (op inside {SUB, BGT, BLT, BEQ, BNE}) ? 2'b10 : 2'b00;
        alu_src = op inside {ANDI, ADDI, LW, LW_POI, SW};
        ext     = op inside {ADDI, LW, LW_POI, SW, BGT, BLT, BEQ, BNE};
        wres    = op inside {LW, LW_POI, POP};
        bw2     = (op == LW_POI);
        mrd     = op inside {LW, LW_POI, RET, POP};
        mwr     = op inside {SW, CALL, PUSH};
        pc      = (op inside {BGT, BLT, BEQ, BNE}) ? 2'b01 :
                  (op inside {JMP, CALL}) ? 2'b10 : (op == RET) ? 2'b11 : 2'b00;
        dma     = op inside {CALL, RET, PUSH, POP};
        dmd     = (op == CALL);
        sp      = op inside {CALL, RET, PUSH, POP};
        return {reg_wr, alu, alu_src, ext, wres, bw2, mrd, mwr, pc, dma, dmd, sp};
    endfunction

    task automatic check(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input int op, input string tag);
        @(negedge clock);
        bus.opcode = 6'(op);
        @(posedge clock);
        #1;
        check(tag, model(op));
    endtask

    always @(negedge clock) begin
        if (reset) begin
            checks++;
            assert (!(bus.MemRd && bus.MemWr) && !(bus.regWr && bus.MemWr))
            else begin
                errors++;
                $error("FAIL invariant observed rd=%b wr=%b regwr=%b expected no conflict",
                       bus.MemRd, bus.MemWr, bus.regWr);
            end
        end
    end

    initial begin
        int          op;
        logic [13:0] expv;
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.opcode  = 6'(ADD);

        #3;
        check("reset_state", '0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_held_over_edges", '0);

        // Release between edges: nothing moves until the next edge.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("release_no_change", '0);
        @(posedge clock);
        #1;
        check("first_edge_add", model(ADD));

        // Asynchronous assertion mid-cycle with ADD registered.
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_midcycle", '0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("after_reset_add", model(ADD));

        for (int i = 0; i <= POP; i++) step(i, $sformatf("directed_op%0d", i));
        step(18, "undefined_18");
        step(63, "undefined_63");

        // Opcode change shortly after an edge stays invisible until the next edge.
        step(ADD, "latency_pre");
        #1;
        bus.opcode = 6'(RET);
        #1;
        check("latency_hold", model(ADD));
        @(posedge clock);
        #1;
        check("latency_update", model(RET));

        @(negedge clock);
        bus.opcode = 6'(POP);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("hold_pop_%0d", i), model(POP));
        end

        expv = model(POP);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clock);
                #2;
                reset = 1'b0;
                #1;
                check("rand_reset", '0);
                reset = 1'b1;
                expv = '0;
                #1;
                check("rand_reset_release", expv);
            end
            op = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 17))
                                             : int'($urandom_range(0, 63));
            step(op, $sformatf("random_%0d_op%0d", i, op));
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Main decoder of the simple RISC processor. It maps the 6-bit instruction opcode to the datapath control signals for ALU, immediate extender, register file write-back, data memory and PC select. Outputs are registered: each rising clock edge captures the decode of the current opcode. It sits between the instruction register and the datapath muxes/enables.

Parameters:
none. Opcode values are shared codebase constants, fixed as listed under Behaviour.

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
opcode  input  6  instruction opcode field
regWr  output  1  register-file write enable
AluOp  output  2  ALU function: 00 AND, 01 ADD, 10 SUB, 11 unused
AluSrc  output  1  ALU operand B: 0 register Rs2, 1 extended immediate
Ext  output  1  immediate extension: 0 zero, 1 sign
Wresult  output  1  write-back source: 0 ALU result, 1 memory data
Bw2  output  1  second write-back enabled (base-register post-increment)
MemRd  output  1  data-memory read enable
MemWr  output  1  data-memory write enable
pc_control  output  2  next PC: 00 PC+1, 01 conditional branch target, 10 jump target, 11 return address from memory
DMadd  output  1  data-memory address: 0 ALU result, 1 stack pointer
DMdata  output  1  data-memory write data: 0 register operand, 1 PC+1
SP  output  1  stack-pointer update enable

Behaviour:
- Opcode values: NOP 0, AND 1, ADD 2, SUB 3, ANDI 4, ADDI 5, LW 6, LW_POI 7, SW 8, BGT 9, BLT 10, BEQ 11, BNE 12, JMP 13, CALL 14, RET 15, PUSH 16, POP 17. Values 18..63 decode as NOP.
- NOP outputs: every output 0, including AluOp=00 and pc_control=00.
- Reset: reset=0 forces all outputs to the NOP values immediately, independent of the clock. They hold while reset is low.
- Timing: on each rising clock edge with reset=1, all outputs load the decode of opcode. Latency is 1 cycle. Outputs are stable between edges and never glitch on opcode changes.
- Decode table. Any signal not listed is 0.
  - AND: regWr=1, AluOp=00.
  - ADD: regWr=1, AluOp=01.
  - SUB: regWr=1, AluOp=10.
  - ANDI: regWr=1, AluOp=00, AluSrc=1, Ext=0.
  - ADDI: regWr=1, AluOp=01, AluSrc=1, Ext=1.
  - LW: regWr=1, AluOp=01, AluSrc=1, Ext=1, MemRd=1, Wresult=1.
  - LW_POI: as LW, plus Bw2=1.
  - SW: AluOp=01, AluSrc=1, Ext=1, MemWr=1, DMdata=0.
  - BGT/BLT/BEQ/BNE: AluOp=10, AluSrc=0, Ext=1, pc_control=01. The branch condition is evaluated by the PC logic, not here.
  - JMP: pc_control=10.
  - CALL: pc_control=10, MemWr=1, DMadd=1, DMdata=1, SP=1.
  - RET: pc_control=11, MemRd=1, DMadd=1, SP=1.
  - PUSH: MemWr=1, DMadd=1, DMdata=0, SP=1.
  - POP: regWr=1, MemRd=1, Wresult=1, DMadd=1, SP=1.
- Invariants on every cycle:
  - MemRd and MemWr are never both 1.
  - regWr=1 implies MemWr=0.
  - Bw2=1 only for LW_POI.
- Opcode changes: a change between edges has no effect until the next rising edge. Holding an opcode for several cycles keeps the outputs constant.
- Reset release: deassertion takes effect with no output change until the first rising edge with reset=1.

Test Plan:
- Reset: reset=0 mid-cycle while opcode=ADD has been registered -> all outputs 0 immediately. Release reset, then one edge -> regWr=1, AluOp=01.
- Opcode sequence: opcode=0, then AND, ADD, SUB, LW, SW, each held 20 ns with a 10 ns clock. One edge after each change:
  - NOP: all 0.
  - AND: regWr=1, AluOp=00.
  - ADD: AluOp=01.
  - SUB: AluOp=10.
  - LW: regWr=1, AluSrc=1, Ext=1, MemRd=1, Wresult=1.
  - SW: MemWr=1, regWr=0, AluSrc=1.
- Control flow:
  - BEQ -> pc_control=01, AluOp=10, regWr=0.
  - JMP -> pc_control=10.
  - CALL -> pc_control=10, MemWr=1, DMadd=1, DMdata=1, SP=1.
  - RET -> pc_control=11, MemRd=1, DMadd=1, SP=1.
- Stack and post-increment:
  - PUSH -> MemWr=1, DMadd=1, SP=1, DMdata=0.
  - POP -> regWr=1, MemRd=1, Wresult=1, DMadd=1, SP=1.
  - LW_POI -> Bw2=1 plus the LW signals.
- Immediates and undefined codes:
  - ANDI -> AluSrc=1, Ext=0.
  - ADDI -> Ext=1.
  - opcode=18 and opcode=63 -> all outputs 0.
- Latency: change opcode 2 ns after an edge -> outputs unchanged until the next edge, then updated. Check MemRd&MemWr=0 on every cycle of every test.
